// File: rtl/per2axi_txn_tracker_pkg.sv
// Shared types for the per2axi transaction tracker: request type encoding,
// per-ID slot state and the mapping from an accepted request to its wait state.
package per2axi_pkg;

   typedef enum logic [1:0] {
      READ  = 2'd0,
      WRITE = 2'd1,
      ATOP  = 2'd2
   } txn_type_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_R  = 2'd1,
      WAIT_B  = 2'd2,
      WAIT_RB = 2'd3
   } slot_state_e;

   // The unnamed encoding 2'b11 falls into the default arm and waits like a WRITE.
   function automatic slot_state_e accept_state(logic [1:0] req_type);
      case (txn_type_t'(req_type))
         READ:    return WAIT_R;
         ATOP:    return WAIT_RB;
         default: return WAIT_B;
      endcase
   endfunction

endpackage

// File: rtl/per2axi_txn_tracker_if.sv
// Request channel plus R/B response handshakes observed by the tracker.
interface per2axi_txn_tracker_if #(
   parameter int AXI_ID_WIDTH = 3
);
   logic                    req_valid;
   logic [AXI_ID_WIDTH-1:0] req_id;
   logic [1:0]              req_type;
   logic                    req_ready;
   logic                    r_hs;
   logic [AXI_ID_WIDTH-1:0] r_id;
   logic                    r_last;
   logic                    b_hs;
   logic [AXI_ID_WIDTH-1:0] b_id;

   modport master (
      output req_valid, req_id, req_type, r_hs, r_id, r_last, b_hs, b_id,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_id, req_type, r_hs, r_id, r_last, b_hs, b_id,
      output req_ready
   );
endinterface

// File: rtl/per2axi_txn_slot.sv
// One tracked AXI ID: outstanding-state FSM plus an optional watchdog,
// compiled in when PER2AXI_TIMEOUT_EN is defined.
module per2axi_txn_slot
   import per2axi_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        accept_i,
   input  logic [1:0]  req_type_i,
   input  logic        r_last_i,
   input  logic        b_i,
   output slot_state_e state_o,
   output logic        timeout_o
);

   slot_state_e state_q, state_d;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept_i) state_d = accept_state(req_type_i);
         WAIT_R:  if (r_last_i) state_d = IDLE;
         WAIT_B:  if (b_i)      state_d = IDLE;
         WAIT_RB: begin
            if (r_last_i && b_i) state_d = IDLE;
            else if (r_last_i)   state_d = WAIT_B;
            else if (b_i)        state_d = WAIT_R;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   assign state_o = state_q;

`ifdef PER2AXI_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Idle slots sit at zero so a stale expiry never outlives the transaction.
   always_comb begin
      cnt_d = cnt_q;
      if (accept_i || state_q == IDLE) cnt_d = '0;
      else if (cnt_q != CNT_MAX)       cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign timeout_o = (state_q != IDLE) && (cnt_q == CNT_MAX);
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/per2axi_txn_tracker.sv
// Per-core AXI transaction tracker: ready mux, response routing, unexpected
// response detection and busy popcount. Watchdog enabled by PER2AXI_TIMEOUT_EN.
module per2axi_txn_tracker
   import per2axi_pkg::*;
#(
   parameter int          NB_CORES       = 4,
   parameter int          AXI_ID_WIDTH   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   per2axi_txn_tracker_if.slave              bus,
   output logic [NB_CORES-1:0]               busy_o,
   output logic [$clog2(NB_CORES+1)-1:0]     outstanding_o,
   output logic                              all_idle_o,
   output logic                              unexp_resp_o,
   output logic [NB_CORES-1:0]               timeout_o
);

   localparam int OW = $clog2(NB_CORES + 1);

   if (NB_CORES < 1 || NB_CORES > (1 << AXI_ID_WIDTH)) begin : g_cores_check
      $error("NB_CORES must be in 1..2**AXI_ID_WIDTH");
   end

   slot_state_e         state [NB_CORES];
   logic [NB_CORES-1:0] accept, r_last_sel, b_sel;
   logic                r_known, b_known, unexp_d, unexp_q;

   // IDs outside 0..NB_CORES-1 match no slot: never ready, always unexpected.
   always_comb begin
      bus.req_ready = 1'b0;
      accept        = '0;
      r_last_sel    = '0;
      b_sel         = '0;
      r_known       = 1'b0;
      b_known       = 1'b0;
      unexp_d       = 1'b0;
      for (int i = 0; i < NB_CORES; i++) begin
         if (bus.req_id == AXI_ID_WIDTH'(i) && state[i] == IDLE) begin
            bus.req_ready = 1'b1;
            accept[i]     = bus.req_valid;
         end
         if (bus.r_id == AXI_ID_WIDTH'(i)) begin
            r_known       = 1'b1;
            r_last_sel[i] = bus.r_hs && bus.r_last;
            if (bus.r_hs && (state[i] == IDLE || state[i] == WAIT_B)) unexp_d = 1'b1;
         end
         if (bus.b_id == AXI_ID_WIDTH'(i)) begin
            b_known  = 1'b1;
            b_sel[i] = bus.b_hs;
            if (bus.b_hs && (state[i] == IDLE || state[i] == WAIT_R)) unexp_d = 1'b1;
         end
      end
      if (bus.r_hs && !r_known) unexp_d = 1'b1;
      if (bus.b_hs && !b_known) unexp_d = 1'b1;
   end

   for (genvar i = 0; i < NB_CORES; i++) begin : g_slot
      per2axi_txn_slot #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_slot (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .accept_i   (accept[i]),
         .req_type_i (bus.req_type),
         .r_last_i   (r_last_sel[i]),
         .b_i        (b_sel[i]),
         .state_o    (state[i]),
         .timeout_o  (timeout_o[i])
      );
      assign busy_o[i] = (state[i] != IDLE);
   end

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < NB_CORES; i++) outstanding_o = outstanding_o + OW'(busy_o[i]);
   end

   assign all_idle_o = (outstanding_o == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) unexp_q <= 1'b0;
      else         unexp_q <= unexp_d;
   end

   assign unexp_resp_o = unexp_q;

endmodule

// File: tb/tb_per2axi_txn_tracker.sv
// Self-checking bench for per2axi_txn_tracker: vector table through a
// scoreboard queue, then watchdog and mid-transaction reset sequences.
module tb_per2axi_txn_tracker;
   import per2axi_pkg::*;

   localparam int NB  = 4;
   localparam int IDW = 3;
   localparam int TO  = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] busy, timeout;
   logic [2:0]    outstanding;
   logic          all_idle, unexp;

   per2axi_txn_tracker_if #(.AXI_ID_WIDTH(IDW)) bus ();

   per2axi_txn_tracker #(
      .NB_CORES       (NB),
      .AXI_ID_WIDTH   (IDW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus           (bus),
      .busy_o        (busy),
      .outstanding_o (outstanding),
      .all_idle_o    (all_idle),
      .unexp_resp_o  (unexp),
      .timeout_o     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [2:0]    id;
      logic [1:0]    ty;
      logic          rh;
      logic [2:0]    rid;
      logic          rl;
      logic          bh;
      logic [2:0]    bid;
      logic          rdy;
      logic [NB-1:0] busy;
      logic          un;
      logic [NB-1:0] to;
   } vec_t;

   typedef struct {
      logic [NB-1:0] busy;
      logic          un;
      logic [NB-1:0] to;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic v, logic [2:0] id, logic [1:0] ty,
                               logic rh, logic [2:0] rid, logic rl,
                               logic bh, logic [2:0] bid,
                               logic rdy, logic [NB-1:0] bz, logic un,
                               logic [NB-1:0] to = '0);
      vec_t r;
      r = '{v, id, ty, rh, rid, rl, bh, bid, rdy, bz, un, to};
      return r;
   endfunction

   task automatic drive_idle();
      bus.req_valid = 1'b0; bus.req_id = '0; bus.req_type = 2'd0;
      bus.r_hs = 1'b0; bus.r_id = '0; bus.r_last = 1'b0;
      bus.b_hs = 1'b0; bus.b_id = '0;
   endtask

   // Called at posedge+1; drives one cycle of stimulus and checks the result.
   task automatic apply_vec(input vec_t v, input string tag);
      exp_t e;
      bus.req_valid = v.valid; bus.req_id = v.id; bus.req_type = v.ty;
      bus.r_hs = v.rh; bus.r_id = v.rid; bus.r_last = v.rl;
      bus.b_hs = v.bh; bus.b_id = v.bid;
      #1;
      check({tag, " ready"}, 32'(bus.req_ready), 32'(v.rdy));
      sb.push_back('{v.busy, v.un, v.to});
      @(posedge clk);
      #1;
      drive_idle();
      if (sb.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s scoreboard: got empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " busy"},        32'(busy),        32'(e.busy));
         check({tag, " outstanding"}, 32'(outstanding), 32'($countones(e.busy)));
         check({tag, " all_idle"},    32'(all_idle),    32'(e.busy == '0));
         check({tag, " unexp"},       32'(unexp),       32'(e.un));
         check({tag, " timeout"},     32'(timeout),     32'(e.to));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [NB-1:0] exp_to;
      drive_idle();
      #7;
      check("reset busy",        32'(busy),        0);
      check("reset outstanding", 32'(outstanding), 0);
      check("reset all_idle",    32'(all_idle),    1);
      check("reset unexp",       32'(unexp),       0);
      check("reset timeout",     32'(timeout),     0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      //                  valid id  type   rh rid rl  bh bid  rdy busy     un
      tbl.push_back(mk(1, 2, READ,  0, 0, 0, 0, 0, 1, 4'b0100, 0)); // READ id2
      tbl.push_back(mk(0, 0, READ,  1, 2, 0, 0, 0, 1, 4'b0100, 0)); // beat 1
      tbl.push_back(mk(0, 0, READ,  1, 2, 0, 0, 0, 1, 4'b0100, 0)); // beat 2
      tbl.push_back(mk(0, 0, READ,  1, 2, 0, 0, 0, 1, 4'b0100, 0)); // beat 3
      tbl.push_back(mk(0, 0, READ,  1, 2, 1, 0, 0, 1, 4'b0000, 0)); // last beat
      tbl.push_back(mk(1, 0, WRITE, 0, 0, 0, 0, 0, 1, 4'b0001, 0)); // WRITE id0
      tbl.push_back(mk(1, 0, WRITE, 0, 0, 0, 0, 0, 0, 4'b0001, 0)); // id0 busy
      tbl.push_back(mk(1, 3, WRITE, 0, 0, 0, 0, 0, 1, 4'b1001, 0)); // WRITE id3
      tbl.push_back(mk(1, 5, READ,  0, 0, 0, 1, 2, 0, 4'b1001, 1)); // B idle id2, id5
      tbl.push_back(mk(1, 7, READ,  0, 0, 0, 0, 0, 0, 4'b1001, 0)); // id7 refused
      tbl.push_back(mk(1, 1, READ,  0, 0, 0, 1, 0, 1, 4'b1010, 0)); // B id0 + READ id1
      tbl.push_back(mk(1, 2, READ,  0, 0, 0, 1, 2, 1, 4'b1110, 1)); // accept + unexp same id
      tbl.push_back(mk(0, 0, READ,  1, 1, 1, 1, 3, 1, 4'b0100, 0)); // R id1 + B id3
      tbl.push_back(mk(0, 0, READ,  1, 6, 1, 0, 0, 1, 4'b0100, 1)); // R id6 out of range
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 1, 2, 1, 4'b0100, 1)); // B to WAIT_R
      tbl.push_back(mk(0, 0, READ,  1, 2, 1, 0, 0, 1, 4'b0000, 0)); // R last id2
      tbl.push_back(mk(1, 0, 2'd3,  0, 0, 0, 0, 0, 1, 4'b0001, 0)); // reserved type
      tbl.push_back(mk(0, 0, READ,  1, 0, 1, 0, 0, 0, 4'b0001, 1)); // R to WAIT_B
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 1, 0, 0, 4'b0000, 0)); // B closes it
      tbl.push_back(mk(1, 1, ATOP,  0, 0, 0, 0, 0, 1, 4'b0010, 0)); // ATOP id1
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 1, 1, 1, 4'b0010, 0)); // B at T
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 1, 1, 1, 4'b0010, 1)); // 2nd B: WAIT_R
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 0, 0, 1, 4'b0010, 0));
      tbl.push_back(mk(0, 0, READ,  1, 1, 1, 0, 0, 1, 4'b0000, 0)); // R last at T+3
      tbl.push_back(mk(1, 1, ATOP,  0, 0, 0, 0, 0, 1, 4'b0010, 0));
      tbl.push_back(mk(0, 0, READ,  1, 1, 1, 1, 1, 1, 4'b0000, 0)); // R+B same cycle
      tbl.push_back(mk(1, 1, ATOP,  0, 0, 0, 0, 0, 1, 4'b0010, 0));
      tbl.push_back(mk(0, 0, READ,  1, 1, 1, 0, 0, 1, 4'b0010, 0)); // R only
      tbl.push_back(mk(0, 0, READ,  1, 1, 1, 0, 0, 1, 4'b0010, 1)); // 2nd R: WAIT_B
      tbl.push_back(mk(0, 0, READ,  0, 0, 0, 1, 1, 1, 4'b0000, 0)); // B closes
      foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Watchdog: READ id1 left unanswered for 20 cycles.
      apply_vec(mk(1, 1, READ, 0, 0, 0, 0, 0, 1, 4'b0010, 0), "to_accept");
      for (int k = 1; k <= 20; k++) begin
`ifdef PER2AXI_TIMEOUT_EN
         exp_to = (k >= TO) ? 4'b0010 : 4'b0000;
`else
         exp_to = 4'b0000;
`endif
         apply_vec(mk(0, 0, READ, 0, 0, 0, 0, 0, 1, 4'b0010, 0, exp_to),
                   $sformatf("to_wait%0d", k));
      end
      apply_vec(mk(0, 0, READ, 1, 1, 1, 0, 0, 1, 4'b0000, 0), "to_close");

      // Reset with three IDs busy and an unexpected pulse pending.
      apply_vec(mk(1, 0, READ,  0, 0, 0, 0, 0, 1, 4'b0001, 0), "rst_a");
      apply_vec(mk(1, 1, WRITE, 0, 0, 0, 0, 0, 1, 4'b0011, 0), "rst_b");
      apply_vec(mk(1, 2, ATOP,  1, 7, 1, 0, 0, 1, 4'b0111, 1), "rst_c");
      #2 rst_n = 1'b0;
      #1;
      check("midrst busy",        32'(busy),          0);
      check("midrst outstanding", 32'(outstanding),   0);
      check("midrst all_idle",    32'(all_idle),      1);
      check("midrst unexp",       32'(unexp),         0);
      check("midrst timeout",     32'(timeout),       0);
      check("midrst ready",       32'(bus.req_ready), 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      apply_vec(mk(0, 0, READ, 1, 0, 1, 0, 0, 1, 4'b0000, 1), "stale_r");
      apply_vec(mk(0, 0, READ, 0, 0, 0, 1, 1, 1, 4'b0000, 1), "stale_b");
      apply_vec(mk(0, 0, READ, 0, 0, 0, 0, 0, 1, 4'b0000, 0), "quiet");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/per2axi_txn_tracker.md
PER2AXI_TXN_TRACKER -- requirements
Module: per2axi_txn_tracker

Interface
- REQ-001: Parameter NB_CORES, default 4, number of tracked transaction IDs (one per core).
- REQ-002: Parameter AXI_ID_WIDTH, default 3, AXI ID width; NB_CORES SHALL be <= 2**AXI_ID_WIDTH (elaboration assertion).
- REQ-003: Parameter TIMEOUT_CYCLES, default 1024, watchdog threshold, used only when PER2AXI_TIMEOUT_EN is defined.
- REQ-004: clk_i  input  1  single clock, all state on rising edge.
- REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
- REQ-006: req_valid_i  input  1  new transaction offered by request channel.
- REQ-007: req_id_i  input  AXI_ID_WIDTH  ID of offered transaction.
- REQ-008: req_type_i  input  2  txn_type_t: READ, WRITE, ATOP.
- REQ-009: req_ready_o  output  1  transaction may be issued this cycle.
- REQ-010: r_hs_i  input  1  AXI R beat handshake (valid and ready).
- REQ-011: r_id_i  input  AXI_ID_WIDTH  R beat ID.
- REQ-012: r_last_i  input  1  R beat is last.
- REQ-013: b_hs_i  input  1  AXI B handshake.
- REQ-014: b_id_i  input  AXI_ID_WIDTH  B ID.
- REQ-015: busy_o  output  NB_CORES  per-ID outstanding flag.
- REQ-016: outstanding_o  output  $clog2(NB_CORES+1)  count of busy IDs.
- REQ-017: all_idle_o  output  1  no transaction outstanding.
- REQ-018: unexp_resp_o  output  1  one-cycle pulse on unexpected response.
- REQ-019: timeout_o  output  NB_CORES  per-ID watchdog expiry flag.

Function
- REQ-020: Per-ID FSM states IDLE, WAIT_R, WAIT_B, WAIT_RB.
- REQ-021: req_ready_o SHALL be combinational: 1 iff req_id_i < NB_CORES and state[req_id_i]==IDLE; ID >= NB_CORES never accepted.
- REQ-022: Accept = req_valid_i & req_ready_o; next cycle state becomes READ->WAIT_R, WRITE->WAIT_B, ATOP->WAIT_RB.
- REQ-023: WAIT_R -> IDLE on r_hs_i & r_last_i with matching ID; non-last beats leave state unchanged.
- REQ-024: WAIT_B -> IDLE on b_hs_i with matching ID.
- REQ-025: WAIT_RB -> WAIT_B on R last only, -> WAIT_R on B only, -> IDLE when both in same cycle.
- REQ-026: R beat to ID in IDLE/WAIT_B, or B to ID in IDLE/WAIT_R, or any response ID >= NB_CORES, SHALL pulse unexp_resp_o next cycle and not change state.
- REQ-027: Accept and responses on different IDs in one cycle SHALL all take effect; accept plus unexpected response on same IDLE ID SHALL accept and flag.
- REQ-028: busy_o[i] = state[i]!=IDLE; outstanding_o = popcount(busy_o); all_idle_o = (outstanding_o==0); all registered-state-derived, no combinational path from inputs.
- REQ-029: Reserved txn_type_t encoding SHALL be treated as WRITE.

Reset
- REQ-030: On rst_ni low all IDs IDLE, busy_o=0, outstanding_o=0, all_idle_o=1, unexp_resp_o=0, timeout_o=0, counters 0; reset mid-transaction discards tracking, later responses flag unexpected.

Configuration
- REQ-031: With PER2AXI_TIMEOUT_EN defined, each ID has a counter cleared on accept, incrementing while busy, saturating at TIMEOUT_CYCLES; timeout_o[i] = counter==TIMEOUT_CYCLES, held until ID returns IDLE.
- REQ-032: Without PER2AXI_TIMEOUT_EN, no counters are instantiated and timeout_o is tied to 0.

Structure
- REQ-033: txn_type_t and FSM state enum SHALL live in shared package per2axi_pkg.
- REQ-034: Per-ID FSM plus optional watchdog SHALL be sub-module per2axi_txn_slot, instantiated NB_CORES times; top holds ready mux, popcount and unexpected-response detection.

Verification
- REQ-035: Accept READ id 2, 4 R beats last on 4th -> busy_o=0100 until cycle after last, then 0000, all_idle_o=1.
- REQ-036: ATOP id 1, B at T, R last at T+3 -> WAIT_R after T, IDLE after T+3; repeat with R and B same cycle -> IDLE in one step.
- REQ-037: WRITE id 0 outstanding, req_valid_i id 0 -> req_ready_o=0; WRITE id 3 same cycle -> accepted, outstanding_o=2.
- REQ-038: B id 2 while id 2 IDLE -> unexp_resp_o=1 for one cycle, busy_o unchanged; req_id_i=5 with NB_CORES=4 -> req_ready_o=0.
- REQ-039: With PER2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16, READ id 1 no response -> timeout_o[1]=1 at 16 cycles after accept, cleared after R last.
- REQ-040: Assert rst_ni low with 3 IDs busy -> all outputs at reset values asynchronously; subsequent stale R -> unexp_resp_o pulse.
